phy_rx_deframer: RTL and testbench
==================================

Name: phy_rx_deframer

Overview:
Receive-side deframer downstream of the transmit top level. It consumes the 4-bit PHY nibble stream plus transmit enable, reassembles bytes and delimits frames. It also checks frame length, nibble alignment and inter-frame gap, and keeps frame and error statistics. It serves as the loopback checker and the receive front end for the forwarding path.

Parameters:
LEN_W, 12, width of the frame length field (matches the 12-bit length fields of the control block)
MIN_LEN, 64, minimum legal frame length in bytes
MAX_LEN, 2047, maximum legal frame length in bytes; must be below 2^LEN_W - 1
MIN_IPG, 2, minimum number of clk_phy cycles with phy_rx_en low between frames
CNT_W, 16, width of the statistics counters

Ports:
clk_phy  in  1  PHY nibble clock; the only clock
reset  in  1  asynchronous, active-low reset
phy_rx_en  in  1  frame envelope; high while nibbles are valid
phy_rx_data  in  4  nibble, low nibble of each byte first
rx_byte  out  8  assembled byte
rx_byte_valid  out  1  rx_byte valid this cycle
rx_sof  out  1  with rx_byte_valid on the first byte of a frame
rx_eof  out  1  one-cycle end-of-frame pulse
rx_len  out  LEN_W  byte count of the frame; valid while rx_eof=1
rx_status  out  3  {odd_nibble, too_short, too_long}; valid while rx_eof=1
rx_ipg_viol  out  1  one-cycle pulse on short inter-frame gap
rx_frame_cnt  out  CNT_W  frames completed with status 000
rx_err_cnt  out  CNT_W  frames completed with status not 000

Behaviour:
- Reset is asynchronous and active-low on all flops. While reset=0, every output is 0, the FSM is in SYNC, and the counters are 0.
- FSM states:
  - SYNC: wait for phy_rx_en=0, then go to IDLE. This is the state after reset, so a frame already in progress at reset release is ignored entirely.
  - IDLE: count low cycles, saturating at MIN_IPG. On phy_rx_en=1, go to LO and capture the low nibble in that same cycle.
  - LO: expect the high nibble. If phy_rx_en=1, assemble {phy_rx_data, lo_nibble} and go to HI-phase accounting. If phy_rx_en=0, a dangling nibble has occurred: set odd_nibble and end the frame.
  - HI: expect the next low nibble. If phy_rx_en=1, capture it and go to LO. If phy_rx_en=0, end the frame.
- Byte latency: rx_byte and rx_byte_valid are registered. A byte whose high nibble is sampled at edge k appears in the cycle after edge k.
- rx_sof is asserted only with the first rx_byte_valid of a frame.
- End of frame: when phy_rx_en=0 is sampled at edge k, rx_eof, rx_len and rx_status are driven in the cycle after edge k. This is exactly one cycle after the last rx_byte_valid, and rx_byte_valid=0 during rx_eof.
- Length counting:
  - The byte counter is LEN_W bits, cleared at frame start and incremented per assembled byte.
  - It saturates at MAX_LEN+1 and sets too_long.
  - Bytes beyond MAX_LEN are not presented (rx_byte_valid suppressed), but reception continues until phy_rx_en falls.
  - too_short is set when the final count is below MIN_LEN.
  - The partial nibble is never counted.
- A frame with only one nibble gives rx_len=0 and status 110.
- IPG check: if phy_rx_en rises after fewer than MIN_IPG low cycles, rx_ipg_viol pulses in the cycle after the rise. The frame is still received normally.
- The IPG counter is pre-saturated on SYNC to IDLE, so the first frame after reset does not flag a violation.
- Counters update in the rx_eof cycle and saturate at all-ones (no wrap).
- Edge cases that are not special:
  - A zero-gap frame merge (en never drops) is one long frame.
  - Simultaneous rx_eof and rx_ipg_viol are legal.

Decomposition:
- Shared package (xmit_pkg): LEN_W, MIN_LEN, MAX_LEN, MIN_IPG; rx_status bit index constants (ST_ODD=2, ST_SHORT=1, ST_LONG=0); FSM state encoding (SYNC, IDLE, LO, HI).
- One sub-module, rx_stat_counter: saturating CNT_W counter with increment enable, instantiated for frame and error counts.

Test Plan:
1. 64-byte frame, 128 nibbles forming bytes 0x00..0x3F:
   - 64 rx_byte_valid with correct values, rx_sof on 0x00;
   - rx_eof with rx_len=0x040 and status 000;
   - rx_frame_cnt=1.
2. 512-byte frame of 0xF0 (nibbles 0,F repeated), gap 4:
   - 512 bytes of 0xF0, rx_len=0x200, status 000;
   - no rx_ipg_viol.
3. 129-nibble frame:
   - 64 bytes delivered;
   - rx_len=0x040, status 100;
   - rx_err_cnt increments.
4. Length limits:
   - 10-byte frame gives status 010 and rx_len=10;
   - 2100-byte frame gives 2047 bytes delivered, rx_len=2048 and status 001.
5. Two 64-byte frames separated by a 1-cycle gap:
   - rx_ipg_viol pulses once;
   - both frames report status 000;
   - rx_frame_cnt=2.
6. reset=0 for 3 cycles midway through a 512-byte frame, with phy_rx_en still high:
   - all outputs are 0 immediately (asynchronous);
   - no bytes until phy_rx_en drops;
   - the following 64-byte frame is received cleanly with rx_frame_cnt=1.

Source files
------------

// File: rtl/xmit_pkg.sv
// Shared constants for the PHY receive path: frame length limits, gap limit,
// status bit positions and the deframer state encoding.
package xmit_pkg;

  localparam int unsigned LEN_W   = 12;
  localparam int unsigned MIN_LEN = 64;
  localparam int unsigned MAX_LEN = 2047;
  localparam int unsigned MIN_IPG = 2;
  localparam int unsigned IPG_W   = $clog2(MIN_IPG + 1);

  localparam int unsigned ST_ODD   = 2;
  localparam int unsigned ST_SHORT = 1;
  localparam int unsigned ST_LONG  = 0;

  localparam logic [1:0] StSync = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StLo   = 2'd2;
  localparam logic [1:0] StHi   = 2'd3;

  // A saturated count of MAX_LEN+1 is the only way too_long can be reported.
  function automatic logic [2:0] rx_status_f(input logic odd, input logic [LEN_W-1:0] len);
    logic [2:0] st;
    st           = '0;
    st[ST_ODD]   = odd;
    st[ST_SHORT] = (len < LEN_W'(MIN_LEN));
    st[ST_LONG]  = (len == LEN_W'(MAX_LEN + 1));
    return st;
  endfunction

endpackage

// File: rtl/rx_stat_counter.sv
// Saturating statistics counter with increment enable.
module rx_stat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_phy,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: rebuilds bytes from the low-first nibble stream, delimits
// frames on phy_rx_en, checks length, nibble alignment and inter-frame gap.
module phy_rx_deframer
  import xmit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_phy,
  input  logic             reset,
  input  logic             phy_rx_en,
  input  logic [3:0]       phy_rx_data,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic [LEN_W-1:0] rx_len,
  output logic [2:0]       rx_status,
  output logic             rx_ipg_viol,
  output logic [CNT_W-1:0] rx_frame_cnt,
  output logic [CNT_W-1:0] rx_err_cnt
);

  logic [1:0]       state_d, state_q;
  logic [3:0]       lo_nib_d, lo_nib_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic [IPG_W-1:0] ipg_d, ipg_q;

  logic [7:0]       byte_d, byte_q;
  logic             byte_valid_d, byte_valid_q;
  logic             sof_d, sof_q;
  logic             eof_d, eof_q;
  logic [LEN_W-1:0] len_out_d, len_out_q;
  logic [2:0]       status_d, status_q;
  logic             ipg_viol_d, ipg_viol_q;

  logic             frame_inc, err_inc;

  always_comb begin
    state_d      = state_q;
    lo_nib_d     = lo_nib_q;
    len_d        = len_q;
    ipg_d        = ipg_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    len_out_d    = '0;
    status_d     = '0;
    ipg_viol_d   = 1'b0;

    unique case (state_q)
      StSync: begin
        // Pre-saturate the gap so the first frame after reset is never flagged.
        if (!phy_rx_en) begin
          state_d = StIdle;
          ipg_d   = IPG_W'(MIN_IPG);
        end
      end
      StIdle: begin
        if (phy_rx_en) begin
          state_d    = StLo;
          lo_nib_d   = phy_rx_data;
          len_d      = '0;
          ipg_viol_d = (ipg_q < IPG_W'(MIN_IPG));
        end else if (ipg_q < IPG_W'(MIN_IPG)) begin
          ipg_d = ipg_q + IPG_W'(1);
        end
      end
      StLo: begin
        if (phy_rx_en) begin
          state_d = StHi;
          // Bytes past MAX_LEN are still counted (to saturation) but not presented.
          if (len_q < LEN_W'(MAX_LEN)) begin
            byte_d       = {phy_rx_data, lo_nib_q};
            byte_valid_d = 1'b1;
            sof_d        = (len_q == '0);
          end
          if (len_q <= LEN_W'(MAX_LEN)) begin
            len_d = len_q + LEN_W'(1);
          end
        end else begin
          state_d   = StIdle;
          eof_d     = 1'b1;
          len_out_d = len_q;
          status_d  = rx_status_f(1'b1, len_q);
          ipg_d     = IPG_W'(1);
        end
      end
      StHi: begin
        if (phy_rx_en) begin
          state_d  = StLo;
          lo_nib_d = phy_rx_data;
        end else begin
          state_d   = StIdle;
          eof_d     = 1'b1;
          len_out_d = len_q;
          status_d  = rx_status_f(1'b0, len_q);
          ipg_d     = IPG_W'(1);
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state_q      <= StSync;
      lo_nib_q     <= '0;
      len_q        <= '0;
      ipg_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      len_out_q    <= '0;
      status_q     <= '0;
      ipg_viol_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_nib_q     <= lo_nib_d;
      len_q        <= len_d;
      ipg_q        <= ipg_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      len_out_q    <= len_out_d;
      status_q     <= status_d;
      ipg_viol_q   <= ipg_viol_d;
    end
  end

  assign frame_inc = eof_q && (status_q == 3'b000);
  assign err_inc   = eof_q && (status_q != 3'b000);

  rx_stat_counter #(
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk_phy (clk_phy),
    .reset   (reset),
    .inc     (frame_inc),
    .count   (rx_frame_cnt)
  );

  rx_stat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk_phy (clk_phy),
    .reset   (reset),
    .inc     (err_inc),
    .count   (rx_err_cnt)
  );

  assign rx_byte       = byte_q;
  assign rx_byte_valid = byte_valid_q;
  assign rx_sof        = sof_q;
  assign rx_eof        = eof_q;
  assign rx_len        = len_out_q;
  assign rx_status     = status_q;
  assign rx_ipg_viol   = ipg_viol_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Randomized bench for phy_rx_deframer against a frame-level reference model.
module tb_phy_rx_deframer;
  import xmit_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic             clk_phy = 1'b0;
  logic             rst_n = 1'b0;
  logic             phy_rx_en = 1'b0;
  logic [3:0]       phy_rx_data = 4'h0;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             rx_sof;
  logic             rx_eof;
  logic [LEN_W-1:0] rx_len;
  logic [2:0]       rx_status;
  logic             rx_ipg_viol;
  logic [CNT_W-1:0] rx_frame_cnt;
  logic [CNT_W-1:0] rx_err_cnt;

  phy_rx_deframer #(
    .CNT_W (CNT_W)
  ) dut (
    .clk_phy       (clk_phy),
    .reset         (rst_n),
    .phy_rx_en     (phy_rx_en),
    .phy_rx_data   (phy_rx_data),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_len        (rx_len),
    .rx_status     (rx_status),
    .rx_ipg_viol   (rx_ipg_viol),
    .rx_frame_cnt  (rx_frame_cnt),
    .rx_err_cnt    (rx_err_cnt)
  );

  always #5 clk_phy = ~clk_phy;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: frames are described as nibble lists.
  logic [3:0]  nib[$];
  logic [8:0]  exp_bytes[$], obs_bytes[$];   // {sof, byte}
  logic [15:0] exp_eofs[$], obs_eofs[$];     // {byte_in_prev_cycle, len, status}
  int          exp_viol = 0, obs_viol = 0;
  int          exp_frames = 0, exp_errs = 0;
  int          low_run = 100;
  bit          after_sync = 1'b1;

  // Monitor
  logic prev_valid = 1'b0;
  always @(negedge clk_phy) begin
    if (rst_n) begin
      if (rx_byte_valid) obs_bytes.push_back({rx_sof, rx_byte});
      if (rx_sof) check_eq("sof_with_byte", 32'(rx_byte_valid), 32'd1);
      if (rx_eof) begin
        obs_eofs.push_back({prev_valid, rx_len, rx_status});
        check_eq("eof_no_byte", 32'(rx_byte_valid), 32'd0);
      end
      if (rx_ipg_viol) obs_viol++;
    end
    prev_valid = rx_byte_valid;
  end

  task automatic build_frame(input int nbytes, input int kind);
    logic [7:0] b;
    nib.delete();
    for (int i = 0; i < nbytes; i++) begin
      case (kind)
        0:       b = 8'(i);
        1:       b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      nib.push_back(b[3:0]);
      nib.push_back(b[7:4]);
    end
  endtask

  // Drive the current frame after a gap of at least `gap` low cycles, model its results.
  task automatic run_frame(input int gap);
    int   nbytes, len_rep;
    logic odd, too_short, too_long, pv;
    while (low_run < gap) begin
      @(negedge clk_phy);
      phy_rx_en = 1'b0;
      low_run++;
    end
    if (low_run < int'(MIN_IPG) && !after_sync) exp_viol++;
    after_sync = 1'b0;
    foreach (nib[i]) begin
      @(negedge clk_phy);
      phy_rx_en   = 1'b1;
      phy_rx_data = nib[i];
    end
    @(negedge clk_phy);
    phy_rx_en = 1'b0;
    low_run   = 1;

    nbytes = nib.size() / 2;
    odd    = nib.size() % 2 != 0;
    for (int i = 0; i < nbytes && i < int'(MAX_LEN); i++)
      exp_bytes.push_back({i == 0, nib[2*i+1], nib[2*i]});
    len_rep   = (nbytes > int'(MAX_LEN)) ? int'(MAX_LEN) + 1 : nbytes;
    too_short = len_rep < int'(MIN_LEN);
    too_long  = nbytes > int'(MAX_LEN);
    pv        = !odd && nbytes >= 1 && nbytes <= int'(MAX_LEN);
    exp_eofs.push_back({pv, LEN_W'(len_rep), odd, too_short, too_long});
    if (odd || too_short || too_long) exp_errs++;
    else exp_frames++;
  endtask

  task automatic flush_compare(input string tag);
    repeat (6) begin
      @(negedge clk_phy);
      phy_rx_en = 1'b0;
      low_run++;
    end
    check_eq({tag, "_nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
      check_eq({tag, "_byte"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
    check_eq({tag, "_neof"}, 32'(obs_eofs.size()), 32'(exp_eofs.size()));
    for (int i = 0; i < exp_eofs.size() && i < obs_eofs.size(); i++)
      check_eq({tag, "_eof"}, 32'(obs_eofs[i]), 32'(exp_eofs[i]));
    check_eq({tag, "_ipg_viol"}, 32'(obs_viol), 32'(exp_viol));
    check_eq({tag, "_frame_cnt"}, 32'(rx_frame_cnt), 32'(exp_frames));
    check_eq({tag, "_err_cnt"}, 32'(rx_err_cnt), 32'(exp_errs));
    exp_bytes.delete();
    obs_bytes.delete();
    exp_eofs.delete();
    obs_eofs.delete();
    exp_viol = 0;
    obs_viol = 0;
  endtask

  initial begin
    #2;
    check_eq("reset_misc", 32'({rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_len, rx_status,
                                rx_ipg_viol}), 32'd0);
    check_eq("reset_frame_cnt", 32'(rx_frame_cnt), 32'd0);
    check_eq("reset_err_cnt", 32'(rx_err_cnt), 32'd0);
    repeat (2) @(negedge clk_phy);
    rst_n = 1'b1;

    // Counting frame, then 0xF0 frame after a 4-cycle gap
    build_frame(64, 0);
    run_frame(4);
    build_frame(512, 1);
    run_frame(4);
    flush_compare("t1_t2");

    // Dangling nibble
    build_frame(64, 0);
    nib.push_back(4'h5);
    run_frame(4);
    flush_compare("t3_odd");

    // Length limits and single-nibble frame
    build_frame(10, 2);
    run_frame(3);
    build_frame(2100, 2);
    run_frame(3);
    nib.delete();
    nib.push_back(4'hA);
    run_frame(3);
    flush_compare("t4_len");

    // One-cycle gap between two legal frames
    build_frame(64, 2);
    run_frame(4);
    build_frame(64, 2);
    run_frame(1);
    flush_compare("t5_ipg");

    // Random frames with random gaps
    for (int r = 0; r < 12; r++) begin
      int nn;
      nn = $urandom_range(1, 260);
      nib.delete();
      for (int i = 0; i < nn; i++) nib.push_back(4'($urandom));
      run_frame($urandom_range(1, 5));
      if (r % 4 == 3) flush_compare("rand");
    end

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_phy);
      phy_rx_en   = 1'b1;
      phy_rx_data = 4'($urandom);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_misc", 32'({rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_len, rx_status,
                                   rx_ipg_viol}), 32'd0);
    check_eq("t6_async_frame_cnt", 32'(rx_frame_cnt), 32'd0);
    check_eq("t6_async_err_cnt", 32'(rx_err_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk_phy);
      phy_rx_data = 4'($urandom);
    end
    rst_n = 1'b1;
    obs_bytes.delete();
    obs_eofs.delete();
    obs_viol   = 0;
    exp_frames = 0;
    exp_errs   = 0;
    after_sync = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_phy);
      phy_rx_en   = 1'b1;
      phy_rx_data = 4'($urandom);
    end
    @(negedge clk_phy);
    phy_rx_en = 1'b0;
    low_run   = 1;
    build_frame(64, 2);
    run_frame(3);
    flush_compare("t6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
